// File: rtl/isa_pkg.sv
// isa_pkg: opcodes, flag bit positions and the per-opcode {z_en, vn_en} flag-update enables
package isa_pkg;
  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;
  function automatic logic [1:0] flags_update(input logic [3:0] op);
    return {op inside {OP_ADD, OP_SUB, OP_XOR, OP_SLL, OP_SRA, OP_ROR}, op inside {OP_ADD, OP_SUB}};
  endfunction
endpackage

// File: rtl/wb_skid_buf.sv
// wb_skid_buf: 2-entry head/tail FIFO (in_valid/in_ready/in_data -> out_valid/out_ready/out_data, count); head holds last value when empty
module wb_skid_buf #(
  parameter int W = 20,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);
  logic [W-1:0] head, tail;
  logic push, pop;
  assign in_ready = count != 2'(DEPTH);
  assign out_valid = count != 2'd0;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign out_data = head;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      if (push && (count == 2'd0 || pop)) head <= in_data;
      else if (push) tail <= in_data;
      else if (pop && count == 2'd2) head <= tail;
    end
  end
endmodule

// File: rtl/exwb_stage.sv
// exwb_stage: EX->WB stage (in_valid/in_ready/in_result/in_opcode/in_rd/in_ovfl -> wb_valid/wb_ready/wb_we/wb_rd/wb_data) with 2-deep skid buffer and {Z,V,N} flags
module exwb_stage import isa_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int RD_W = 4,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [3:0]        in_opcode,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_ovfl,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic              wb_we,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [2:0]        flags
);
  logic [1:0] count, en;
  assign en = flags_update(in_opcode);
  wb_skid_buf #(.W(RD_W + DATA_W), .DEPTH(DEPTH)) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data({in_rd, in_result}),
    .out_valid(wb_valid),
    .out_ready(wb_ready),
    .out_data({wb_rd, wb_data}),
    .count(count)
  );
  assign wb_we = count != 2'd0 && wb_rd != '0;
  always_ff @(posedge clk) begin
    if (!rst_n) flags <= 3'b000;
    else if (in_valid && in_ready) begin
      if (en[1]) flags[FLAG_Z] <= in_result == '0;
      if (en[0]) flags[FLAG_V] <= in_ovfl;
      if (en[0]) flags[FLAG_N] <= in_result[DATA_W-1];
    end
  end
endmodule
